// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator: each channel emits a one-cycle ce pulse
// every N+1 clocks, with divisor changes deferred to the period boundary.
module clken_gen #(
  parameter int CHANNELS  = 4,
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                run,
  input  logic                sync,
  input  logic                div_we,
  input  logic [2:0]          div_sel,
  input  logic [DIV_W-1:0]    div_data,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
);

  logic [DIV_W-1:0]    div_q  [CHANNELS];
  logic [DIV_W-1:0]    pend_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] pv_q;
  logic [CHANNELS-1:0] seen_q;

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] apply;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] seen_hold;

  // Writes with an out-of-range channel index match no channel and are dropped.
  always_comb begin
    hit   = '0;
    wrap  = '0;
    apply = '0;
    clr   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i]   = div_we && (div_sel == 3'(i));
      wrap[i]  = run && !sync && (cnt_q[i] == div_q[i]);
      apply[i] = wrap[i] && pv_q[i];
      clr[i]   = sync || apply[i];
    end
    seen_hold = seen_q & ~clr;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ce     <= '0;
      locked <= 1'b0;
      pv_q   <= '0;
      seen_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_W'(RESET_DIV);
        pend_q[i] <= '0;
      end
    end else begin
      // locked drops on the very edge a channel loses its seen flag
      locked <= &seen_hold;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync) begin
          cnt_q[i]  <= '0;
          ce[i]     <= 1'b0;
          pv_q[i]   <= 1'b0;
          seen_q[i] <= 1'b0;
          if (hit[i])
            div_q[i] <= div_data;
          else if (pv_q[i])
            div_q[i] <= pend_q[i];
        end else begin
          if (wrap[i]) begin
            cnt_q[i] <= '0;
            ce[i]    <= 1'b1;
          end else begin
            ce[i] <= 1'b0;
            if (run)
              cnt_q[i] <= cnt_q[i] + 1'b1;
          end
          if (apply[i])
            div_q[i] <= pend_q[i];
          // A write landing on the wrap edge becomes the next pending value
          if (hit[i]) begin
            pend_q[i] <= div_data;
            pv_q[i]   <= 1'b1;
          end else if (apply[i]) begin
            pv_q[i] <= 1'b0;
          end
          seen_q[i] <= apply[i] ? 1'b0 : (seen_q[i] | wrap[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Scoreboard bench for clken_gen: a cycle model pushes expected ce/locked per
// driven cycle, popped and compared one time unit after the following edge.
module tb_clken_gen;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam int RD = 3;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          run;
  logic          sync;
  logic          div_we;
  logic [2:0]    div_sel;
  logic [DW-1:0] div_data;
  logic [CH-1:0] ce;
  logic          locked;

  always #5 clock = ~clock;

  clken_gen #(.CHANNELS(CH), .DIV_W(DW), .RESET_DIV(RD)) dut (
    .clock(clock), .rst_n(rst_n), .run(run), .sync(sync), .div_we(div_we),
    .div_sel(div_sel), .div_data(div_data), .ce(ce), .locked(locked)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [CH-1:0] ce;
    logic          locked;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] m_div [CH];
  logic [DW-1:0] m_pend[CH];
  logic [DW-1:0] m_cnt [CH];
  logic          m_pv  [CH];
  logic [CH-1:0] m_ce;
  logic [CH-1:0] m_seen;
  logic          m_locked;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      m_div[i]  = DW'(RD);
      m_pend[i] = '0;
      m_cnt[i]  = '0;
      m_pv[i]   = 1'b0;
    end
    m_ce     = '0;
    m_seen   = '0;
    m_locked = 1'b0;
  endtask

  // Reference behaviour of one rising edge, written from the channel rules.
  task automatic modelStep(input logic r, input logic s, input logic w,
                           input logic [2:0] sel, input logic [DW-1:0] d);
    logic [CH-1:0] hold;
    logic          hit;
    logic          applied;
    hold = '0;
    for (int i = 0; i < CH; i++) begin
      hit     = w && (sel == 3'(i));
      applied = 1'b0;
      if (s) begin
        m_cnt[i] = '0;
        m_ce[i]  = 1'b0;
        if (hit) m_div[i] = d;
        else if (m_pv[i]) m_div[i] = m_pend[i];
        m_pv[i]   = 1'b0;
        m_seen[i] = 1'b0;
      end else begin
        hold[i] = m_seen[i];
        if (r && (m_cnt[i] == m_div[i])) begin
          m_cnt[i] = '0;
          m_ce[i]  = 1'b1;
          if (m_pv[i]) begin
            m_div[i] = m_pend[i];
            m_pv[i]  = 1'b0;
            applied  = 1'b1;
          end
        end else begin
          if (r) m_cnt[i] = m_cnt[i] + 1'b1;
          m_ce[i] = 1'b0;
        end
        if (hit) begin
          m_pend[i] = d;
          m_pv[i]   = 1'b1;
        end
        if (applied) begin
          m_seen[i] = 1'b0;
          hold[i]   = 1'b0;
        end else if (m_ce[i]) begin
          m_seen[i] = 1'b1;
        end
      end
    end
    m_locked = &hold;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic w,
                               input logic [2:0] sel, input logic [DW-1:0] d,
                               input string tag);
    exp_t e;
    @(negedge clock);
    run = r; sync = s; div_we = w; div_sel = sel; div_data = d;
    modelStep(r, s, w, sel, d);
    sb.push_back('{ce: m_ce, locked: m_locked});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checkOutput({tag, "_ce"}, 32'(ce), 32'(e.ce));
    checkOutput({tag, "_locked"}, 32'(locked), 32'(e.locked));
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, tag);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; sync = 1'b0; div_we = 1'b0; div_sel = '0; div_data = '0;
    modelReset();
    #12;
    checkOutput("reset_ce", 32'(ce), 32'h0);
    checkOutput("reset_locked", 32'(locked), 32'h0);
    @(negedge clock);
    #2 rst_n = 1'b1;

    // Defaults: all channels pulse on edges 4, 8, 12; locked follows edge 4
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "startup");
      if (k == 3) checkOutput("startup_edge3", 32'(ce), 32'h0);
      if (k == 4) checkOutput("startup_edge4", 32'(ce), 32'hF);
      if (k == 4) checkOutput("startup_lock4", 32'(locked), 32'h0);
      if (k == 5) checkOutput("startup_lock5", 32'(locked), 32'h1);
      if (k == 8) checkOutput("startup_edge8", 32'(ce), 32'hF);
    end

    // N=0 on ch1 mid-period: applied at the wrap, then ce[1] stays high
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "n0_pre");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 8'd0, "n0_wr");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "n0_wait");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "n0_apply");
    checkOutput("n0_apply_locked", 32'(locked), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "n0_p1");
    checkOutput("n0_p1_ce1", 32'(ce[1]), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "n0_p2");
    checkOutput("n0_p2_locked", 32'(locked), 32'h1);
    checkOutput("n0_p2_ce1", 32'(ce[1]), 32'h1);

    // Last write wins on ch2: N=9 overwritten by N=1 before the wrap
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 8'd9, "lww_w9");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 8'd1, "lww_w1");
    idle(12, "lww_run");

    // Freeze at cnt=2 for five cycles, then two edges to the next pulse
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, '0, "frz_sync");
    idle(2, "frz_pre");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, '0, "frz_hold");
      checkOutput("frz_hold_ce", 32'(ce), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "frz_r1");
    checkOutput("frz_r1_ce0", 32'(ce[0]), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "frz_r2");
    checkOutput("frz_r2_ce0", 32'(ce[0]), 32'h1);

    // Sync with a simultaneous write: ch0 becomes N=5 at once
    idle(1, "syw_pre");
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 8'd5, "syw_sync");
    checkOutput("syw_sync_ce", 32'(ce), 32'h0);
    checkOutput("syw_sync_locked", 32'(locked), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "syw_run");
      if (k == 4) checkOutput("syw_e4_ce3", 32'(ce[3]), 32'h1);
      if (k == 4) checkOutput("syw_e4_ce0", 32'(ce[0]), 32'h0);
      if (k == 6) checkOutput("syw_e6_ce0", 32'(ce[0]), 32'h1);
    end
    idle(8, "syw_post");

    // Out-of-range channel index must leave every channel untouched
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd7, 8'd0, "oor_wr");
    idle(12, "oor_run");

    // Mixed random traffic
    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                    DW'($urandom_range(0, 5)), "rnd");
    end

    // Reset mid-period with a pending write: pending value is discarded
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 8'd0, "rst_wr");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ce", 32'(ce), 32'h0);
    checkOutput("rst_mid_locked", 32'(locked), 32'h0);
    run = 1'b0; sync = 1'b0; div_we = 1'b0;
    modelReset();
    @(negedge clock);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, '0, "rst_rel");
    checkOutput("rst_rel_ce", 32'(ce), 32'h0);
    idle(9, "rst_run");

    checkOutput("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
